i2c_reg_target: RTL and testbench

Register-mapped I2C responder (target) that runs on the system clock and oversamples the bus. It terminates I2C_master transactions as a small byte-addressed register file: a pointer byte selects the register, data bytes follow, and the pointer auto-increments. It sits on the shared SCL/SDA net beside the existing subordinates. A local host port reads the register file and observes every bus write.

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_bus_sync.sv | 29 ++
 rtl/i2c_reg_target.sv | 175 +++++++++++++++++
 tb/tb_i2c_reg_target.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state encoding and I2C bit constants
package i2c_pkg;
  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RACK,
    S_IGNORE
  } tgt_state_e;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: synchronizes SCL/SDA and flags SCL edges plus START/STOP
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  logic [2:0] scl_q;
  logic [2:0] sda_q;
  // two synchronizer stages plus one history stage; idle bus is high so reset to 1
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  assign sda_o      = sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  assign start_o    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_o     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
endmodule

// File: rtl/i2c_reg_target.sv
// i2c_reg_target: I2C target exposing a byte-addressed register file with auto-incrementing pointer
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] MY_ADDR = 7'h50,
  parameter int NREGS = 16,
  localparam int PW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          SCL,
  inout  wire           SDA,
  input  logic [PW-1:0] host_addr,
  output logic [7:0]    host_rdata,
  output logic          wr_strobe,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          rd_strobe,
  output logic          busy,
  output logic [3:0]    state_out
);
  tgt_state_e state_q, state_d;
  logic [7:0] regs_q [NREGS];
  logic [7:0] sh_q, sh_d;
  logic [2:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic oe_q, oe_d, busy_q, busy_d, rw_q, rw_d, full_q, full_d;
  logic wr_strobe_q, wr_strobe_d, rd_strobe_q, rd_strobe_d;
  logic sda_s, scl_rise, scl_fall, start_ev, stop_ev;
  logic match, rx_st;
  logic [7:0] cur;
  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (SCL),
    .sda_i     (SDA),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_ev),
    .stop_o    (stop_ev)
  );
  assign match = sh_q[7:1] == MY_ADDR;
  assign rx_st = state_q == S_ADDR || state_q == S_PTR || state_q == S_WDATA;
  assign cur   = regs_q[ptr_q];
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  // next state: bus conditions override bit handling in every state
  always_comb begin
    state_d = state_q;
    if (start_ev) state_d = S_ADDR;
    else if (stop_ev) state_d = S_IDLE;
    else
      case (state_q)
        S_ADDR:      if (scl_fall && full_q) state_d = match ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK:  if (scl_fall) state_d = (rw_q == I2C_RW_WRITE) ? S_PTR : S_RDATA;
        S_PTR:       if (scl_fall && full_q) state_d = S_PTR_ACK;
        S_PTR_ACK:   if (scl_fall) state_d = S_WDATA;
        S_WDATA:     if (scl_fall && full_q) state_d = S_WDATA_ACK;
        S_WDATA_ACK: if (scl_fall) state_d = S_WDATA;
        S_RDATA:     if (scl_fall && cnt_q == 3'd7) state_d = S_RACK;
        S_RACK:      if (scl_rise && sda_s == NACK) state_d = S_IGNORE;
                     else if (scl_fall && full_q) state_d = S_RDATA;
        default: ;
      endcase
  end
  // datapath and outputs; full_q marks a completed byte (or a master ACK) awaiting the next SCL fall
  always_comb begin
    oe_d = oe_q;
    busy_d = busy_q;
    rw_d = rw_q;
    cnt_d = cnt_q;
    full_d = full_q;
    sh_d = sh_q;
    ptr_d = ptr_q;
    wr_strobe_d = 1'b0;
    rd_strobe_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (start_ev || stop_ev) begin
      oe_d = 1'b0;
      busy_d = 1'b0;
      cnt_d = '0;
      full_d = 1'b0;
    end else if (rx_st && scl_rise) begin
      sh_d = {sh_q[6:0], sda_s};
      cnt_d = cnt_q + 3'd1;
      full_d = cnt_q == 3'd7;
    end else if (scl_fall) begin
      case (state_q)
        S_ADDR: if (full_q) begin
          full_d = 1'b0;
          oe_d = match;
          busy_d = match;
          rw_d = sh_q[0];
        end
        S_PTR: if (full_q) begin
          full_d = 1'b0;
          oe_d = 1'b1;
          ptr_d = sh_q[PW-1:0];
        end
        S_WDATA: if (full_q) begin
          full_d = 1'b0;
          oe_d = 1'b1;
          wr_strobe_d = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = sh_q;
          ptr_d = ptr_q + 1'b1;
        end
        S_ADDR_ACK, S_RACK: begin
          oe_d = 1'b0;
          full_d = 1'b0;
          if (state_q == S_RACK ? full_q : rw_q == I2C_RW_READ) begin
            sh_d = cur;
            oe_d = ~cur[7];
            rd_strobe_d = 1'b1;
            cnt_d = '0;
          end
        end
        S_PTR_ACK, S_WDATA_ACK: oe_d = 1'b0;
        S_RDATA: begin
          oe_d = cnt_q != 3'd7 && !sh_q[6];
          sh_d = {sh_q[6:0], 1'b0};
          cnt_d = cnt_q + 3'd1;
        end
        default: ;
      endcase
    end else if (scl_rise && state_q == S_RACK) begin
      ptr_d = ptr_q + 1'b1;
      full_d = sda_s == ACK;
    end
  end
  // datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      oe_q <= 1'b0;
      busy_q <= 1'b0;
      rw_q <= 1'b0;
      cnt_q <= '0;
      full_q <= 1'b0;
      sh_q <= '0;
      ptr_q <= '0;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      oe_q <= oe_d;
      busy_q <= busy_d;
      rw_q <= rw_d;
      cnt_q <= cnt_d;
      full_q <= full_d;
      sh_q <= sh_d;
      ptr_q <= ptr_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  // register file, written on the same edge the write strobe rises
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    else if (wr_strobe_d) regs_q[wr_addr_d] <= wr_data_d;
  assign SDA        = oe_q ? 1'b0 : 1'bz;
  assign host_rdata = regs_q[host_addr];
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rd_strobe  = rd_strobe_q;
  assign busy       = busy_q;
  assign state_out  = state_q;
endmodule

// File: tb/tb_i2c_reg_target.sv
// tb_i2c_reg_target: bit-banged I2C master against a register-array reference model
module tb_i2c_reg_target;
  import i2c_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  wire SDA;
  logic [3:0] host_addr = '0;
  logic [7:0] host_rdata, wr_data;
  logic [3:0] wr_addr;
  logic wr_strobe, rd_strobe, busy;
  logic [3:0] state_out;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] mregs [16];
  int mptr = 0;
  logic [7:0] txq [$];
  logic [11:0] wq [$];
  logic [11:0] exp_w [$];
  int rd_cnt = 0;
  logic dut_low = 1'b0;
  logic busy_seen = 1'b0;

  assign SDA = m_sda ? 1'bz : 1'b0;
  pullup (SDA);

  i2c_reg_target dut (
    .clk       (clk),
    .rst       (rst),
    .SCL       (m_scl),
    .SDA       (SDA),
    .host_addr (host_addr),
    .host_rdata(host_rdata),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_strobe (rd_strobe),
    .busy      (busy),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) wq.push_back({wr_addr, wr_data});
    if (rd_strobe) rd_cnt++;
    if (m_sda && SDA === 1'b0) dut_low = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic q();
    repeat (4) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, output logic r);
    m_sda = b;
    q();
    m_scl = 1'b1;
    q();
    r = (SDA !== 1'b0);
    q();
    m_scl = 1'b0;
    q();
  endtask

  task automatic start_c();
    m_sda = 1'b1;
    q();
    m_scl = 1'b1;
    q();
    m_sda = 1'b0;
    q();
    m_scl = 1'b0;
    q();
  endtask

  task automatic stop_c();
    m_sda = 1'b0;
    q();
    m_scl = 1'b1;
    q();
    m_sda = 1'b1;
    q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(b[i], r);
    bit_x(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, r);
      d[i] = r;
    end
    bit_x(mack, r);
  endtask

  task automatic hchk(input int i);
    host_addr = 4'(i);
    #1;
    chk($sformatf("host_rdata[%0d]", i), host_rdata, mregs[i]);
  endtask

  // pointer write followed by every byte in txq
  task automatic do_write(input logic [7:0] p);
    logic a;
    wq.delete();
    exp_w.delete();
    start_c();
    write_byte(8'hA0, a);
    chk("w_addr_ack", a, ACK);
    write_byte(p, a);
    chk("w_ptr_ack", a, ACK);
    mptr = p % 16;
    foreach (txq[i]) begin
      write_byte(txq[i], a);
      chk("w_data_ack", a, ACK);
      mregs[mptr] = txq[i];
      exp_w.push_back({4'(mptr), txq[i]});
      mptr = (mptr + 1) % 16;
    end
    chk("w_busy", busy, 1'b1);
    stop_c();
    q();
    chk("w_busy_stop", busy, 1'b0);
    chk("w_nstrobe", wq.size(), exp_w.size());
    foreach (exp_w[i]) if (i < wq.size()) chk("w_strobe", wq[i], exp_w[i]);
  endtask

  // optional pointer set, then (repeated) START and an n-byte read, NACK on the last
  task automatic do_read(input logic [7:0] p, input logic set_ptr, input int n);
    logic a;
    logic [7:0] d;
    if (set_ptr) begin
      start_c();
      write_byte(8'hA0, a);
      chk("r_waddr_ack", a, ACK);
      write_byte(p, a);
      chk("r_ptr_ack", a, ACK);
      mptr = p % 16;
    end
    rd_cnt = 0;
    start_c();
    write_byte(8'hA1, a);
    chk("r_addr_ack", a, ACK);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      chk("r_data", d, mregs[mptr]);
      mptr = (mptr + 1) % 16;
    end
    chk("r_busy", busy, 1'b1);
    stop_c();
    q();
    chk("r_busy_stop", busy, 1'b0);
    chk("r_nstrobe", rd_cnt, n);
  endtask

  task automatic bad_addr(input logic [6:0] a7, input logic rw, input int n);
    logic a;
    wq.delete();
    rd_cnt = 0;
    dut_low = 1'b0;
    busy_seen = 1'b0;
    start_c();
    write_byte({a7, rw}, a);
    chk("bad_addr_nack", a, NACK);
    for (int i = 0; i < n; i++) write_byte(8'hFF, a);
    stop_c();
    q();
    chk("bad_sda_low", dut_low, 1'b0);
    chk("bad_busy", busy_seen, 1'b0);
    chk("bad_wstrobe", wq.size(), 0);
    chk("bad_rstrobe", rd_cnt, 0);
  endtask

  initial begin
    logic a, r;
    logic [7:0] p;
    foreach (mregs[i]) mregs[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", state_out, S_IDLE);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wstb", wr_strobe, 1'b0);
    chk("rst_rstb", rd_strobe, 1'b0);
    chk("rst_waddr", wr_addr, 4'h0);
    chk("rst_wdata", wr_data, 8'h00);
    chk("rst_sda_low", SDA === 1'b0, 1'b0);
    rst = 1'b0;
    q();
    for (int i = 0; i < 16; i++) hchk(i);

    txq = '{8'h11, 8'h22};
    do_write(8'h03);
    hchk(3);
    hchk(4);

    do_read(8'h04, 1'b1, 2);

    bad_addr(7'h51, 1'b0, 8);
    bad_addr(7'h00, 1'b0, 2);

    txq = '{8'hAA, 8'hBB};
    do_write(8'h0F);
    hchk(15);
    hchk(0);
    do_read(8'h00, 1'b0, 1);

    // abort: second data byte cut after 4 bits by STOP
    wq.delete();
    start_c();
    write_byte(8'hA0, a);
    chk("ab_addr_ack", a, ACK);
    write_byte(8'h06, a);
    chk("ab_ptr_ack", a, ACK);
    write_byte(8'h5A, a);
    chk("ab_data_ack", a, ACK);
    mregs[6] = 8'h5A;
    for (int i = 0; i < 4; i++) bit_x(1'b1, r);
    stop_c();
    q();
    chk("ab_nstrobe", wq.size(), 1);
    if (wq.size() > 0) chk("ab_strobe", wq[0], {4'h6, 8'h5A});
    chk("ab_state", state_out, S_IDLE);
    chk("ab_sda_low", SDA === 1'b0, 1'b0);
    hchk(6);
    hchk(7);

    // reset while the target drives the MSB (0) of a read byte
    txq = '{8'h3C};
    do_write(8'h09);
    start_c();
    write_byte(8'hA0, a);
    write_byte(8'h09, a);
    start_c();
    write_byte(8'hA1, a);
    chk("rr_addr_ack", a, ACK);
    chk("rr_sda_driven", SDA === 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk("rr_sda_release", SDA === 1'b0, 1'b0);
    foreach (mregs[i]) mregs[i] = '0;
    mptr = 0;
    m_scl = 1'b1;
    m_sda = 1'b1;
    q();
    chk("rr_state", state_out, S_IDLE);
    for (int i = 0; i < 16; i++) hchk(i);
    rst = 1'b0;
    q();
    txq = '{8'hC3, 8'h7E};
    do_write(8'h0E);

    for (int it = 0; it < 16; it++) begin
      p = 8'($urandom);
      case ($urandom_range(0, 2))
        0: begin
          txq.delete();
          for (int i = 0; i < int'($urandom_range(1, 4)); i++) txq.push_back(8'($urandom));
          do_write(p);
        end
        1: do_read(p, 1'b1, int'($urandom_range(1, 3)));
        default: begin
          logic [6:0] a7;
          a7 = 7'($urandom);
          if (a7 == 7'h50) a7 = 7'h2A;
          bad_addr(a7, 1'($urandom), 1);
        end
      endcase
    end
    for (int i = 0; i < 16; i++) hchk(i);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
